// File: rtl/gate_apply_controller.sv
// gate_apply_controller
//   Client side of the gate-matrix load handshake. It accepts a gate command,
//   requests the 2x2 complex matrix from the gate matrix table, snapshots the
//   matrix on done_pulse, then sweeps every amplitude pair (i0, i1) of the
//   state memory. Each pair is transformed in place: [a0';a1'] = M*[a0;a1].
//
// Handshakes:
//   cmd_valid/cmd_ready : a command transfers on a rising edge where both are
//                         high. cmd_ready is high only in IDLE. The source must
//                         hold cmd_valid and the payload until that edge.
//   ready/done_pulse    : ready is a one-cycle request with gate held stable;
//                         the table answers later with a one-cycle done_pulse
//                         that carries a valid matrix. done_pulse outside WAIT
//                         is ignored.
//
// Ports:
//   clk, reset_n             clock, asynchronous active-low reset
//   cmd_valid/ready/gate/target   command from the instruction sequencer
//   gate, ready, matrix, done_pulse   gate matrix table interface
//   amp_addr, amp_rd_re/im, amp_we, amp_wr_re/im   state memory
//                                (synchronous read, 1-cycle latency)
//   busy, done               status; done strobes when the sweep finishes
//   state_dbg                current FSM state
//
// Optional feature (macro GATE_APPLY_IDENTITY_SKIP_EN):
//   When defined, gate code 0 is treated as identity and the controller goes
//   straight from IDLE to FIN with no table request and no memory traffic.
//
// Fixed-point: signed 37-bit, FRAC_BITS fractional bits. Row sums are
// computed at full width, shifted right arithmetically (floor), then wrapped
// to 37 bits without saturation.
module gate_apply_controller #(
  parameter int NUM_QUBITS = 4,
  parameter int FRAC_BITS  = 17
) (
  input  logic                          clk,
  input  logic                          reset_n,
  input  logic                          cmd_valid,
  output logic                          cmd_ready,
  input  logic [4:0]                    cmd_gate,
  input  logic [$clog2(NUM_QUBITS)-1:0] cmd_target,
  output logic [4:0]                    gate,
  output logic                          ready,
  input  logic signed [36:0]            matrix [0:1][0:1][0:1],
  input  logic                          done_pulse,
  output logic [NUM_QUBITS-1:0]         amp_addr,
  input  logic signed [36:0]            amp_rd_re,
  input  logic signed [36:0]            amp_rd_im,
  output logic                          amp_we,
  output logic signed [36:0]            amp_wr_re,
  output logic signed [36:0]            amp_wr_im,
  output logic                          busy,
  output logic                          done,
  output logic [3:0]                    state_dbg
);

  localparam int TW = $clog2(NUM_QUBITS);
  localparam int PW = NUM_QUBITS - 1;
  localparam logic [TW:0]   NQ_W     = (TW + 1)'(NUM_QUBITS);
  localparam logic [TW-1:0] TGT_MAX  = TW'(NUM_QUBITS - 1);
  localparam logic [NUM_QUBITS-1:0] ONE = NUM_QUBITS'(1);

  typedef enum logic [3:0] {
    IDLE = 4'd0, REQ = 4'd1, WAIT = 4'd2, RD0 = 4'd3, RD1 = 4'd4,
    CALC = 4'd5, WR0 = 4'd6, WR1 = 4'd7, FIN = 4'd8
  } state_t;

  state_t state, state_nx;

  logic [TW-1:0]     tgt;
  logic [PW-1:0]     p;
  logic signed [36:0] m [0:1][0:1][0:1];
  logic signed [36:0] a0_re, a0_im;
  logic signed [36:0] res_re [0:1];
  logic signed [36:0] res_im [0:1];

  // Full-width complex row sums; a1 comes straight from the read port in CALC.
  logic signed [75:0] acc_re [0:1];
  logic signed [75:0] acc_im [0:1];

  logic [NUM_QUBITS-1:0] p_ext, low_mask, i0, i1;
  logic [TW-1:0]         tgt_in;

  function automatic logic signed [75:0] mul(input logic signed [36:0] a,
                                             input logic signed [36:0] b);
    return 76'(a) * 76'(b);
  endfunction

  function automatic logic signed [36:0] scale(input logic signed [75:0] s);
    return 37'(s >>> FRAC_BITS);
  endfunction

  // Out-of-range targets collapse onto the highest qubit.
  assign tgt_in = ({1'b0, cmd_target} >= NQ_W) ? TGT_MAX : cmd_target;

  // Pair addresses: i0 is p with a zero spliced in at bit tgt; i1 sets that bit.
  always_comb begin
    p_ext    = NUM_QUBITS'(p);
    low_mask = (ONE << tgt) - ONE;
    i0       = ((p_ext & ~low_mask) << 1) | (p_ext & low_mask);
    i1       = i0 | (ONE << tgt);
  end

  always_comb begin
    for (int r = 0; r < 2; r++) begin
      acc_re[r] = '0;
      acc_im[r] = '0;
    end
    for (int r = 0; r < 2; r++) begin
      acc_re[r] = mul(m[r][0][0], a0_re) - mul(m[r][0][1], a0_im)
                + mul(m[r][1][0], amp_rd_re) - mul(m[r][1][1], amp_rd_im);
      acc_im[r] = mul(m[r][0][0], a0_im) + mul(m[r][0][1], a0_re)
                + mul(m[r][1][0], amp_rd_im) + mul(m[r][1][1], amp_rd_re);
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= IDLE;
      gate  <= '0;
      tgt   <= '0;
      p     <= '0;
      a0_re <= '0;
      a0_im <= '0;
      for (int r = 0; r < 2; r++) begin
        res_re[r] <= '0;
        res_im[r] <= '0;
        for (int c = 0; c < 2; c++)
          for (int i = 0; i < 2; i++)
            m[r][c][i] <= '0;
      end
    end else begin
      state <= state_nx;
      case (state)
        IDLE: if (cmd_valid) begin
          gate <= cmd_gate;
          tgt  <= tgt_in;
        end
        WAIT: if (done_pulse) m <= matrix;
        RD1: begin
          a0_re <= amp_rd_re;
          a0_im <= amp_rd_im;
        end
        CALC: for (int r = 0; r < 2; r++) begin
          res_re[r] <= scale(acc_re[r]);
          res_im[r] <= scale(acc_im[r]);
        end
        WR1: if (!(&p)) p <= p + PW'(1);
        FIN: p <= '0;
        default: ;
      endcase
    end
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE: if (cmd_valid) begin
`ifdef GATE_APPLY_IDENTITY_SKIP_EN
        state_nx = (cmd_gate == 5'd0) ? FIN : REQ;
`else
        state_nx = REQ;
`endif
      end
      REQ:  state_nx = WAIT;
      WAIT: if (done_pulse) state_nx = RD0;
      RD0:  state_nx = RD1;
      RD1:  state_nx = CALC;
      CALC: state_nx = WR0;
      WR0:  state_nx = WR1;
      WR1:  state_nx = (&p) ? FIN : RD0;
      FIN:  state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_comb begin
    cmd_ready = (state == IDLE);
    busy      = (state != IDLE);
    ready     = (state == REQ);
    done      = (state == FIN);
    amp_we    = (state == WR0) || (state == WR1);
    amp_addr  = ((state == RD1) || (state == WR1)) ? i1 : i0;
    amp_wr_re = (state == WR1) ? res_re[1] : res_re[0];
    amp_wr_im = (state == WR1) ? res_im[1] : res_im[0];
  end

  assign state_dbg = state;

endmodule

// File: tb/tb_gate_apply_controller.sv
module tb_gate_apply_controller;
  localparam int NQ    = 2;
  localparam int FB    = 17;
  localparam int TW    = $clog2(NQ);
  localparam int DEPTH = 1 << NQ;
  localparam int NPAIR = DEPTH / 2;
  localparam int W     = NQ + 74;
  localparam int SWEEP = NPAIR * 5 + 1;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic reset_n = 1'b1;
  always #5 clk = ~clk;

  logic                    cmd_valid = 1'b0;
  logic                    cmd_ready;
  logic [4:0]              cmd_gate = '0;
  logic [TW-1:0]           cmd_target = '0;
  logic [4:0]              gate;
  logic                    ready;
  logic signed [36:0]      matrix [0:1][0:1][0:1];
  logic                    done_pulse = 1'b0;
  logic [NQ-1:0]           amp_addr;
  logic signed [36:0]      amp_rd_re, amp_rd_im;
  logic                    amp_we;
  logic signed [36:0]      amp_wr_re, amp_wr_im;
  logic                    busy, done;
  logic [3:0]              state_dbg;

  gate_apply_controller #(.NUM_QUBITS(NQ), .FRAC_BITS(FB)) dut (
    .clk(clk), .reset_n(reset_n),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_gate(cmd_gate), .cmd_target(cmd_target),
    .gate(gate), .ready(ready), .matrix(matrix), .done_pulse(done_pulse),
    .amp_addr(amp_addr), .amp_rd_re(amp_rd_re), .amp_rd_im(amp_rd_im),
    .amp_we(amp_we), .amp_wr_re(amp_wr_re), .amp_wr_im(amp_wr_im),
    .busy(busy), .done(done), .state_dbg(state_dbg)
  );

  // ---------------- state memory ----------------
  logic signed [36:0] mem_re [DEPTH];
  logic signed [36:0] mem_im [DEPTH];
  logic signed [36:0] init_re [DEPTH];
  logic signed [36:0] init_im [DEPTH];
  logic               mem_load = 1'b0;

  always @(posedge clk) begin
    if (mem_load) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_re[i] <= init_re[i];
        mem_im[i] <= init_im[i];
      end
    end else if (amp_we) begin
      mem_re[amp_addr] <= amp_wr_re;
      mem_im[amp_addr] <= amp_wr_im;
    end
    amp_rd_re <= mem_re[amp_addr];
    amp_rd_im <= mem_im[amp_addr];
  end

  // ---------------- model state ----------------
  logic signed [36:0] mdl_m [0:1][0:1][0:1];
  logic signed [36:0] mdl_re [DEPTH];
  logic signed [36:0] mdl_im [DEPTH];
  logic [W-1:0]       exp_q [$];

  int n_vec = 0;
  int n_bad = 0;
  int wr_cnt = 0;
  int ready_cnt = 0;
  int done_cnt = 0;

  task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic check37(input string name, input logic signed [36:0] act, input logic signed [36:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // floor(x / 2**FB)
  function automatic longint fdiv(input longint x);
    longint d, q;
    d = longint'(1) << FB;
    q = x / d;
    if ((x < 0) && (x % d != 0)) q = q - 1;
    return q;
  endfunction

  // Applies mdl_m to every amplitude pair of the model memory, queueing the
  // writes in sweep order (i0 then i1 for p = 0, 1, ...).
  task automatic model_gate(input int tgt);
    int step, lo, hi, i0, i1;
    longint ar [2];
    longint ai [2];
    longint mr, mi, sr, si;
    logic signed [36:0] yr [2];
    logic signed [36:0] yi [2];
    logic [NQ-1:0] ad;
    step = 1 << tgt;
    for (int p = 0; p < NPAIR; p++) begin
      lo = p % step;
      hi = p / step;
      i0 = hi * 2 * step + lo;
      i1 = i0 + step;
      ar[0] = longint'(mdl_re[i0]); ai[0] = longint'(mdl_im[i0]);
      ar[1] = longint'(mdl_re[i1]); ai[1] = longint'(mdl_im[i1]);
      for (int r = 0; r < 2; r++) begin
        sr = 0; si = 0;
        for (int c = 0; c < 2; c++) begin
          mr = longint'(mdl_m[r][c][0]);
          mi = longint'(mdl_m[r][c][1]);
          sr = sr + mr * ar[c] - mi * ai[c];
          si = si + mr * ai[c] + mi * ar[c];
        end
        yr[r] = 37'(fdiv(sr));
        yi[r] = 37'(fdiv(si));
      end
      ad = NQ'(i0); exp_q.push_back({ad, yr[0], yi[0]});
      ad = NQ'(i1); exp_q.push_back({ad, yr[1], yi[1]});
      mdl_re[i0] = yr[0]; mdl_im[i0] = yi[0];
      mdl_re[i1] = yr[1]; mdl_im[i1] = yi[1];
    end
  endtask

  // ---------------- scoreboard compare ----------------
  always @(negedge clk) begin
    if (reset_n) begin
      if (ready) ready_cnt++;
      if (done) done_cnt++;
      if (amp_we) begin
        wr_cnt++;
        if (exp_q.size() == 0) begin
          n_vec++;
          n_bad++;
          $display("FAIL unexpected_write: got addr %0d data %0d,%0d expected no write", amp_addr, amp_wr_re, amp_wr_im);
        end else begin
          check("write", {amp_addr, amp_wr_re, amp_wr_im}, exp_q.pop_front());
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic mem_clear();
    for (int i = 0; i < DEPTH; i++) begin
      init_re[i] = '0;
      init_im[i] = '0;
    end
  endtask

  task automatic load_mem();
    for (int i = 0; i < DEPTH; i++) begin
      mdl_re[i] = init_re[i];
      mdl_im[i] = init_im[i];
    end
    @(negedge clk); mem_load = 1'b1;
    @(negedge clk); mem_load = 1'b0;
  endtask

  task automatic set_m(input longint m00r, input longint m00i, input longint m01r, input longint m01i,
                       input longint m10r, input longint m10i, input longint m11r, input longint m11i);
    mdl_m[0][0][0] = 37'(m00r); mdl_m[0][0][1] = 37'(m00i);
    mdl_m[0][1][0] = 37'(m01r); mdl_m[0][1][1] = 37'(m01i);
    mdl_m[1][0][0] = 37'(m10r); mdl_m[1][0][1] = 37'(m10i);
    mdl_m[1][1][0] = 37'(m11r); mdl_m[1][1][1] = 37'(m11i);
  endtask

  task automatic set_junk_matrix();
    for (int r = 0; r < 2; r++)
      for (int c = 0; c < 2; c++)
        for (int i = 0; i < 2; i++)
          matrix[r][c][i] = 37'sd12345;
  endtask

  // One full gate: command, table request, done_pulse, sweep, FIN.
  // cont   : command is already on the bus and the DUT is idle right now.
  // spur   : keep done_pulse high (with a junk matrix) through RD0.
  // hold   : after acceptance, keep cmd_valid high with the next command.
  task automatic run_gate(input logic [4:0] g, input int t, input bit cont, input bit spur,
                          input bit hold, input logic [4:0] ng, input int nt);
    int cyc;
    wr_cnt = 0; ready_cnt = 0; done_cnt = 0;
    model_gate(t);
    if (!cont) @(negedge clk);
    cmd_valid = 1'b1; cmd_gate = g; cmd_target = TW'(t);
    cyc = 0;
    while (!cmd_ready && cyc < 50) begin @(negedge clk); cyc++; end
    check("cmd_accept", cmd_ready, 1);
    @(posedge clk); #1;
    if (hold) begin cmd_gate = ng; cmd_target = TW'(nt); end
    else cmd_valid = 1'b0;
    @(negedge clk);
    check("ready_after_accept", ready, 1);
    check("gate_out", gate, g);
    repeat (3) begin
      @(negedge clk);
      check("ready_one_cycle", ready, 0);
      check("gate_held", gate, g);
      check("busy_wait", busy, 1);
    end
    matrix = mdl_m; done_pulse = 1'b1;
    for (int k = 1; k <= SWEEP; k++) begin
      @(negedge clk);
      if (k == 1 && spur) set_junk_matrix();
      else begin done_pulse = 1'b0; set_junk_matrix(); end
      check("done_timing", done, (k == SWEEP));
      check("busy_sweep", busy, 1);
      check("cmd_ready_busy", cmd_ready, 0);
    end
    @(negedge clk);
    check("done_clear", done, 0);
    check("busy_clear", busy, 0);
    check("cmd_ready_idle", cmd_ready, 1);
    check("write_count", W'(wr_cnt), W'(2 * NPAIR));
    check("ready_count", W'(ready_cnt), 1);
    check("done_count", W'(done_cnt), 1);
    check("exp_q_empty", W'(exp_q.size()), 0);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int cyc;
    set_junk_matrix();
    mem_clear();
    set_m(0, 0, 0, 0, 0, 0, 0, 0);

    // Reset values
    #1 reset_n = 1'b0;
    #2;
    check("rst_cmd_ready", cmd_ready, 1);
    check("rst_ready", ready, 0);
    check("rst_amp_we", amp_we, 0);
    check("rst_done", done, 0);
    check("rst_busy", busy, 0);
    check("rst_gate", gate, 0);
    check("rst_amp_addr", amp_addr, 0);
    repeat (2) @(negedge clk);
    reset_n = 1'b1;

    // X on qubit 0: |00> -> |01>
    mem_clear(); init_re[0] = 37'sd131072; load_mem();
    set_m(0, 0, 131072, 0, 131072, 0, 0, 0);
    run_gate(5'd1, 0, 1'b0, 1'b0, 1'b0, 5'd0, 0);
    check37("x_addr0_re", mem_re[0], 37'sd0);
    check37("x_addr1_re", mem_re[1], 37'sd131072);
    check37("x_addr1_im", mem_im[1], 37'sd0);

    // H-like on qubit 1; 92682*131072 >> 17 is exact
    mem_clear(); init_re[0] = 37'sd131072; load_mem();
    set_m(92682, 0, 92682, 0, 92682, 0, -92682, 0);
    run_gate(5'd2, 1, 1'b0, 1'b0, 1'b0, 5'd0, 0);
    check37("h_addr0_re", mem_re[0], 37'sd92682);
    check37("h_addr2_re", mem_re[2], 37'sd92682);
    check37("h_addr0_im", mem_im[0], 37'sd0);
    check37("h_addr1_re", mem_re[1], 37'sd0);

    // Imaginary diagonal: i*(1000 - 3i) = 3 + 1000i
    mem_clear(); init_re[0] = 37'sd1000; init_im[0] = -37'sd3; load_mem();
    set_m(0, 131072, 0, 0, 0, 0, 0, -131072);
    run_gate(5'd3, 0, 1'b0, 1'b0, 1'b0, 5'd0, 0);
    check37("cplx_addr0_re", mem_re[0], 37'sd3);
    check37("cplx_addr0_im", mem_im[0], 37'sd1000);

    // Floor rounding and 37-bit wrap: diag(0.5, 2.0)
    mem_clear();
    init_re[0] = -37'sd3; init_im[0] = 37'sd5;
    init_re[1] = 37'sd34359738368; init_im[1] = -37'sd1;
    load_mem();
    set_m(65536, 0, 0, 0, 0, 0, 262144, 0);
    run_gate(5'd4, 0, 1'b0, 1'b0, 1'b0, 5'd0, 0);
    check37("floor_neg_re", mem_re[0], -37'sd2);
    check37("floor_pos_im", mem_im[0], 37'sd2);
    check37("wrap_re", mem_re[1], -37'sd68719476736);
    check37("wrap_im", mem_im[1], -37'sd2);

    // Held second command plus spurious done_pulse during RD0
    mem_clear(); init_re[0] = 37'sd131072; load_mem();
    set_m(0, 0, 131072, 0, 131072, 0, 0, 0);
    run_gate(5'd1, 0, 1'b0, 1'b1, 1'b1, 5'd6, 1);
    check37("hold_first_addr1", mem_re[1], 37'sd131072);
    set_m(65536, 0, 0, 0, 0, 0, 65536, 0);
    run_gate(5'd6, 1, 1'b1, 1'b0, 1'b0, 5'd0, 0);
    check37("hold_second_addr1", mem_re[1], 37'sd65536);
    check37("hold_second_addr0", mem_re[0], 37'sd0);

`ifdef GATE_APPLY_IDENTITY_SKIP_EN
    // Identity skip: done one cycle after acceptance, no traffic
    wr_cnt = 0; ready_cnt = 0; done_cnt = 0;
    @(negedge clk); cmd_valid = 1'b1; cmd_gate = 5'd0; cmd_target = '0;
    cyc = 0;
    while (!cmd_ready && cyc < 50) begin @(negedge clk); cyc++; end
    check("skip_accept", cmd_ready, 1);
    @(posedge clk); #1 cmd_valid = 1'b0;
    @(negedge clk);
    check("skip_done", done, 1);
    check("skip_ready", ready, 0);
    @(negedge clk);
    check("skip_idle", cmd_ready, 1);
    check("skip_writes", W'(wr_cnt), 0);
    check("skip_ready_count", W'(ready_cnt), 0);
`else
    // Gate 0 with an identity matrix goes through the normal sweep
    mem_clear(); init_re[3] = 37'sd5; init_im[3] = -37'sd7; load_mem();
    set_m(131072, 0, 0, 0, 0, 0, 131072, 0);
    run_gate(5'd0, 1, 1'b0, 1'b0, 1'b0, 5'd0, 0);
    check37("ident_addr3_re", mem_re[3], 37'sd5);
    check37("ident_addr3_im", mem_im[3], -37'sd7);
`endif

    // Reset in the middle of WR0
    mem_clear(); init_re[0] = 37'sd131072; load_mem();
    set_m(0, 0, 131072, 0, 131072, 0, 0, 0);
    model_gate(0);
    @(negedge clk); cmd_valid = 1'b1; cmd_gate = 5'd1; cmd_target = '0;
    cyc = 0;
    while (!cmd_ready && cyc < 50) begin @(negedge clk); cyc++; end
    @(posedge clk); #1 cmd_valid = 1'b0;
    repeat (2) @(negedge clk);
    matrix = mdl_m; done_pulse = 1'b1;
    @(negedge clk); done_pulse = 1'b0;
    cyc = 0;
    while (!amp_we && cyc < 20) begin @(negedge clk); cyc++; end
    check("reach_wr0", amp_we, 1);
    #2 reset_n = 1'b0;
    #1;
    check("arst_amp_we", amp_we, 0);
    check("arst_ready", ready, 0);
    check("arst_busy", busy, 0);
    check("arst_done", done, 0);
    exp_q.delete();
    @(negedge clk); reset_n = 1'b1;
    @(negedge clk);
    check("post_rst_cmd_ready", cmd_ready, 1);
    check("post_rst_amp_addr", amp_addr, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

  initial begin
    #200000;
    n_vec++;
    n_bad++;
    $display("FAIL watchdog: got timeout expected completion");
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
